// File: rtl/game_session_if.sv
// game_session_if: collision/control strobes into the session controller and game status out of it.
interface game_session_if #(
    parameter int DIGITS  = 4,
    parameter int LIVES_W = 2
);
    logic                  tick_i;
    logic                  start_i;
    logic                  hit_i;
    logic                  kill_i;
    logic [3:0]            kill_pts_i;
    logic [1:0]            state_o;
    logic [LIVES_W-1:0]    lives_o;
    logic [4*DIGITS-1:0]   score_bcd_o;
    logic [4*DIGITS-1:0]   hiscore_bcd_o;
    logic                  freeze_o;
    logic                  game_over_o;
    logic                  new_hi_o;

    modport master (
        output tick_i, start_i, hit_i, kill_i, kill_pts_i,
        input  state_o, lives_o, score_bcd_o, hiscore_bcd_o, freeze_o, game_over_o, new_hi_o
    );

    modport slave (
        input  tick_i, start_i, hit_i, kill_i, kill_pts_i,
        output state_o, lives_o, score_bcd_o, hiscore_bcd_o, freeze_o, game_over_o, new_hi_o
    );
endinterface

// File: rtl/game_session_ctrl.sv
// game_session_ctrl: Asteroids session FSM owning game state, lives, saturating BCD score and high score.
module game_session_ctrl #(
    parameter int DIGITS         = 4,
    parameter int LIVES_W        = 2,
    parameter int START_LIVES    = 3,
    parameter int RESPAWN_FRAMES = 120,
    parameter int TIMER_W        = 8
) (
    input logic           clk,
    input logic           rst_n,
    game_session_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_OVER = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [LIVES_W-1:0]  lives_q, lives_d;
    logic [4*DIGITS-1:0] score_q, score_d;
    logic [4*DIGITS-1:0] hiscore_q, hiscore_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                new_hi_q, new_hi_d;
    logic                freeze_q, game_over_q;
    logic [4*DIGITS-1:0] kill_score;
    logic [4*DIGITS-1:0] sum_bcd;
    logic [4:0]          cy, dig;
    logic [3:0]          pts;

    assign pts = (bus.kill_pts_i > 4'd9) ? 4'd9 : bus.kill_pts_i;

    // Decimal ripple add of the kill points; a carry out of the top digit saturates to all nines.
    always_comb begin
        sum_bcd = score_q;
        cy = {1'b0, pts};
        dig = '0;
        for (int k = 0; k < DIGITS; k++) begin
            dig = {1'b0, score_q[4*k +: 4]} + cy;
            sum_bcd[4*k +: 4] = (dig > 5'd9) ? dig[3:0] - 4'd10 : dig[3:0];
            cy = (dig > 5'd9) ? 5'd1 : 5'd0;
        end
        kill_score = (cy != 5'd0) ? {DIGITS{4'h9}} : sum_bcd;
    end

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        score_d   = score_q;
        hiscore_d = hiscore_q;
        timer_d   = timer_q;
        new_hi_d  = new_hi_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (bus.start_i) begin
                    state_d  = S_PLAY;
                    score_d  = '0;
                    lives_d  = LIVES_W'(START_LIVES);
                    new_hi_d = 1'b0;
                end
            end
            S_PLAY: begin
                if (bus.kill_i)
                    score_d = kill_score;
                if (bus.hit_i) begin
                    if (lives_q > LIVES_W'(1)) begin
                        lives_d = lives_q - LIVES_W'(1);
                        timer_d = TIMER_W'(RESPAWN_FRAMES);
                        state_d = (RESPAWN_FRAMES == 0) ? S_PLAY : S_RESP;
                    end else begin
                        lives_d = '0;
                        state_d = S_OVER;
                        // Packed BCD orders the same as its decimal value, so a plain compare works.
                        if (score_d > hiscore_q) begin
                            hiscore_d = score_d;
                            new_hi_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (bus.tick_i) begin
                    timer_d = (timer_q == '0) ? '0 : timer_q - TIMER_W'(1);
                    state_d = (timer_q <= TIMER_W'(1)) ? S_PLAY : S_RESP;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lives_q     <= LIVES_W'(START_LIVES);
            score_q     <= '0;
            hiscore_q   <= '0;
            timer_q     <= '0;
            new_hi_q    <= 1'b0;
            freeze_q    <= 1'b1;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            hiscore_q   <= hiscore_d;
            timer_q     <= timer_d;
            new_hi_q    <= new_hi_d;
            freeze_q    <= state_d != S_PLAY;
            game_over_q <= state_d == S_OVER;
        end
    end

    assign bus.state_o       = state_q;
    assign bus.lives_o       = lives_q;
    assign bus.score_bcd_o   = score_q;
    assign bus.hiscore_bcd_o = hiscore_q;
    assign bus.freeze_o      = freeze_q;
    assign bus.game_over_o   = game_over_q;
    assign bus.new_hi_o      = new_hi_q;
endmodule

// File: tb/tb_game_session_ctrl.sv
// tb_game_session_ctrl: vector table, directed corner sequences and random play against a decimal model.
module tb_game_session_ctrl;
    logic clk;
    logic rst_n;
    int checks;
    int errors;

    game_session_if #(.DIGITS(4), .LIVES_W(2)) if0 ();
    game_session_if #(.DIGITS(4), .LIVES_W(2)) if1 ();

    game_session_ctrl u_dut (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    game_session_ctrl #(.RESPAWN_FRAMES(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    assign if1.tick_i     = if0.tick_i;
    assign if1.start_i    = if0.start_i;
    assign if1.hit_i      = if0.hit_i;
    assign if1.kill_i     = if0.kill_i;
    assign if1.kill_pts_i = if0.kill_pts_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: score kept as a plain decimal integer, state as 0..3.
    int m_state, m_lives, m_score, m_hi, m_timer;
    bit m_new_hi;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_lives = 3; m_score = 0; m_hi = 0; m_timer = 0; m_new_hi = 0;
    endtask

    task automatic model_step(input bit tk, st, ht, kl, input int pts);
        case (m_state)
            0, 3: if (st) begin m_state = 1; m_score = 0; m_lives = 3; m_new_hi = 0; end
            1: begin
                if (kl) m_score = (m_score + (pts > 9 ? 9 : pts) > 9999) ? 9999 : m_score + (pts > 9 ? 9 : pts);
                if (ht) begin
                    if (m_lives > 1) begin m_lives--; m_timer = 120; m_state = 2; end
                    else begin
                        m_lives = 0; m_state = 3;
                        if (m_score > m_hi) begin m_hi = m_score; m_new_hi = 1; end
                    end
                end
            end
            default: if (tk) begin
                if (m_timer <= 1) m_state = 1;
                m_timer = (m_timer > 0) ? m_timer - 1 : 0;
            end
        endcase
    endtask

    task automatic cmp_model();
        chk("state", 32'(if0.state_o), 32'(m_state));
        chk("lives", 32'(if0.lives_o), 32'(m_lives));
        chk("score", 32'(if0.score_bcd_o), 32'(to_bcd(m_score)));
        chk("hiscore", 32'(if0.hiscore_bcd_o), 32'(to_bcd(m_hi)));
        chk("freeze", 32'(if0.freeze_o), 32'(m_state != 1));
        chk("game_over", 32'(if0.game_over_o), 32'(m_state == 3));
        chk("new_hi", 32'(if0.new_hi_o), 32'(m_new_hi));
    endtask

    task automatic step(input bit tk, st, ht, kl, input logic [3:0] pts);
        if0.tick_i = tk; if0.start_i = st; if0.hit_i = ht; if0.kill_i = kl; if0.kill_pts_i = pts;
        @(posedge clk);
        model_step(tk, st, ht, kl, int'(pts));
        #1;
        cmp_model();
        if0.tick_i = 0; if0.start_i = 0; if0.hit_i = 0; if0.kill_i = 0; if0.kill_pts_i = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        cmp_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic kills(input int n, input logic [3:0] pts);
        repeat (n) step(0, 0, 0, 1, pts);
    endtask

    task automatic lose_life();
        step(0, 0, 1, 0, 4'd0);
        repeat (120) step(1, 0, 0, 0, 4'd0);
    endtask

    typedef struct {
        bit tk, st, ht, kl;
        logic [3:0] pts;
        int state_e, score_e, lives_e;
    } vec_t;
    vec_t vt[8];

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b1;
        if0.tick_i = 0; if0.start_i = 0; if0.hit_i = 0; if0.kill_i = 0; if0.kill_pts_i = 0;
        vt[0] = '{0, 1, 0, 0, 4'd0, 1, 0, 3};
        vt[1] = '{0, 0, 0, 1, 4'hF, 1, 9, 3};
        vt[2] = '{0, 0, 0, 1, 4'd9, 1, 18, 3};
        vt[3] = '{0, 1, 0, 1, 4'd7, 1, 25, 3};
        vt[4] = '{0, 0, 1, 0, 4'd0, 2, 25, 2};
        vt[5] = '{0, 0, 1, 1, 4'd5, 2, 25, 2};
        vt[6] = '{1, 0, 0, 0, 4'd0, 2, 25, 2};
        vt[7] = '{0, 0, 0, 1, 4'd9, 2, 25, 2};
        #2;
        do_reset();
        chk("rst_freeze", 32'(if0.freeze_o), 32'd1);

        step(0, 1, 0, 0, 4'd0);
        step(0, 0, 1, 0, 4'd0);
        chk("rf0_state", 32'(if1.state_o), 32'd1);
        chk("rf0_lives", 32'(if1.lives_o), 32'd2);
        chk("rf0_freeze", 32'(if1.freeze_o), 32'd0);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            step(vt[i].tk, vt[i].st, vt[i].ht, vt[i].kl, vt[i].pts);
            chk($sformatf("vec%0d_state", i), 32'(if0.state_o), 32'(vt[i].state_e));
            chk($sformatf("vec%0d_score", i), 32'(if0.score_bcd_o), 32'(to_bcd(vt[i].score_e)));
            chk($sformatf("vec%0d_lives", i), 32'(if0.lives_o), 32'(vt[i].lives_e));
        end
        repeat (118) step(1, 0, 0, 0, 4'd0);
        chk("resp_hold", 32'(if0.state_o), 32'd2);
        step(1, 0, 0, 0, 4'd0);
        chk("resp_done", 32'(if0.state_o), 32'd1);

        kills(8, 4'd9);
        step(0, 0, 0, 1, 4'd1);
        chk("score_98", 32'(if0.score_bcd_o), 32'h0098);
        step(0, 0, 0, 1, 4'd5);
        chk("carry_103", 32'(if0.score_bcd_o), 32'h0103);
        kills(1099, 4'd9);
        step(0, 0, 0, 1, 4'd3);
        chk("score_9997", 32'(if0.score_bcd_o), 32'h9997);
        step(0, 0, 0, 1, 4'd9);
        chk("sat_9999", 32'(if0.score_bcd_o), 32'h9999);
        step(0, 0, 0, 1, 4'hF);
        chk("sat_hold", 32'(if0.score_bcd_o), 32'h9999);

        do_reset();
        step(0, 1, 0, 0, 4'd0);
        kills(11, 4'd9);
        step(0, 0, 0, 1, 4'd1);
        lose_life();
        lose_life();
        step(0, 0, 1, 0, 4'd0);
        chk("g1_hi", 32'(if0.hiscore_bcd_o), 32'h0100);
        step(0, 1, 0, 0, 4'd0);
        kills(27, 4'd9);
        step(0, 0, 0, 1, 4'd7);
        chk("g2_250", 32'(if0.score_bcd_o), 32'h0250);
        lose_life();
        lose_life();
        step(0, 0, 1, 1, 4'd3);
        chk("g2_state", 32'(if0.state_o), 32'd3);
        chk("g2_lives", 32'(if0.lives_o), 32'd0);
        chk("g2_score", 32'(if0.score_bcd_o), 32'h0253);
        chk("g2_hi", 32'(if0.hiscore_bcd_o), 32'h0253);
        chk("g2_new_hi", 32'(if0.new_hi_o), 32'd1);
        chk("g2_over", 32'(if0.game_over_o), 32'd1);

        step(0, 1, 0, 0, 4'd0);
        chk("g3_state", 32'(if0.state_o), 32'd1);
        chk("g3_score", 32'(if0.score_bcd_o), 32'h0000);
        chk("g3_lives", 32'(if0.lives_o), 32'd3);
        chk("g3_hi", 32'(if0.hiscore_bcd_o), 32'h0253);
        chk("g3_new_hi", 32'(if0.new_hi_o), 32'd0);
        kills(22, 4'd9);
        step(0, 0, 0, 1, 4'd2);
        lose_life();
        lose_life();
        step(0, 0, 1, 0, 4'd0);
        chk("g3_end_score", 32'(if0.score_bcd_o), 32'h0200);
        chk("g3_end_hi", 32'(if0.hiscore_bcd_o), 32'h0253);
        chk("g3_end_new_hi", 32'(if0.new_hi_o), 32'd0);

        step(0, 1, 0, 0, 4'd0);
        kills(5, 4'd9);
        step(0, 0, 1, 0, 4'd0);
        repeat (50) step(1, 0, 0, 0, 4'd0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_state", 32'(if0.state_o), 32'd0);
        chk("arst_lives", 32'(if0.lives_o), 32'd3);
        chk("arst_score", 32'(if0.score_bcd_o), 32'h0000);
        chk("arst_hi", 32'(if0.hiscore_bcd_o), 32'h0000);
        chk("arst_freeze", 32'(if0.freeze_o), 32'd1);
        chk("arst_over", 32'(if0.game_over_o), 32'd0);
        chk("arst_new_hi", 32'(if0.new_hi_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 4000; i++)
            step($urandom_range(1, 0) == 0, $urandom_range(29, 0) == 0, $urandom_range(39, 0) == 0,
                 $urandom_range(2, 0) == 0, 4'($urandom_range(15, 0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
